// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: widths, op decode, MEM-stage FSM states.
// Used by the EX and MEM stages.
package mips_pkg;

  localparam int WORD_W       = 32;
  localparam int REG_W        = 5;
  localparam int DM_DEPTH_DEF = 128;
  localparam int DM_ADDR_W    = $clog2(DM_DEPTH_DEF);

  typedef enum logic [1:0] {
    OP_ALU = 2'd0,
    OP_LW  = 2'd1,
    OP_SW  = 2'd2
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Store wins when both flags are raised.
  function automatic op_e decode_op(
    input logic lw,
    input logic sw
  );
    op_e op;
    op = OP_ALU;
    if (sw) begin
      op = OP_SW;
    end else if (lw) begin
      op = OP_LW;
    end
    return op;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// XM -> MEM -> MW bundle with the upstream stall request.
// master = execution side, slave = memory_stage.
interface memory_stage_if;
  import mips_pkg::*;

  logic [WORD_W-1:0] XM_ALUout;
  logic [WORD_W-1:0] XM_B;
  logic [REG_W-1:0]  XM_RD;
  logic              XM_lwFlag;
  logic              XM_swFlag;
  logic              stall;
  logic [WORD_W-1:0] MW_ALUout;
  logic [WORD_W-1:0] MW_memData;
  logic [REG_W-1:0]  MW_RD;
  logic              MW_lwFlag;
  logic              MW_regWrite;

  modport master (
    output XM_ALUout,
    output XM_B,
    output XM_RD,
    output XM_lwFlag,
    output XM_swFlag,
    input  stall,
    input  MW_ALUout,
    input  MW_memData,
    input  MW_RD,
    input  MW_lwFlag,
    input  MW_regWrite
  );

  modport slave (
    input  XM_ALUout,
    input  XM_B,
    input  XM_RD,
    input  XM_lwFlag,
    input  XM_swFlag,
    output stall,
    output MW_ALUout,
    output MW_memData,
    output MW_RD,
    output MW_lwFlag,
    output MW_regWrite
  );

endinterface

// File: rtl/memory_stage_data_mem.sv
// data_mem: single-port synchronous word RAM, registered read port.
// Array is never cleared; only the read register resets.
module data_mem #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: word lw/sw on data_mem, drives the MW register.
// DM_WAIT_EN adds a wait-state FSM that stalls upstream per access.
import mips_pkg::*;

module memory_stage #(
  parameter int DM_DEPTH = DM_DEPTH_DEF
`ifdef DM_WAIT_EN
  ,
  parameter int MEM_WAIT = 2
`endif
) (
  input logic           clk,
  input logic           rst,
  memory_stage_if.slave bus
);

  localparam int AW = $clog2(DM_DEPTH);

  op_e           op;
  logic          is_lw;
  logic          is_sw;
  logic [AW-1:0] idx;
  logic          commit;
  logic [31:0]   rdata;

  assign op    = decode_op(bus.XM_lwFlag, bus.XM_swFlag);
  assign is_lw = (op == OP_LW);
  assign is_sw = (op == OP_SW);
  // Byte offset and out-of-range upper bits are dropped.
  assign idx   = bus.XM_ALUout[AW+1:2];

`ifdef DM_WAIT_EN
  state_e     state;
  state_e     state_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic       stall_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall_c  = 1'b0;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_lw || is_sw) begin
          stall_c  = 1'b1;
          state_nx = WAIT;
          cnt_nx   = 4'(MEM_WAIT - 1);
        end else begin
          commit = 1'b1;
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          stall_c = 1'b1;
          cnt_nx  = cnt - 4'd1;
        end else begin
          commit   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Reset must release upstream at once, even with an op present.
  assign bus.stall = stall_c & ~rst;
`else
  assign commit    = 1'b1;
  assign bus.stall = 1'b0;
`endif

  data_mem #(
    .DEPTH (DM_DEPTH),
    .AW    (AW)
  ) u_dm (
    .clk   (clk),
    .rst   (rst),
    .we    (commit & is_sw),
    .re    (commit & is_lw),
    .addr  (idx),
    .wdata (bus.XM_B),
    .rdata (rdata)
  );

  assign bus.MW_memData = rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.MW_ALUout   <= '0;
      bus.MW_RD       <= '0;
      bus.MW_lwFlag   <= 1'b0;
      bus.MW_regWrite <= 1'b0;
    end else if (commit) begin
      bus.MW_ALUout <= bus.XM_ALUout;
      unique case (1'b1)
        is_sw: begin
          bus.MW_RD       <= '0;
          bus.MW_lwFlag   <= 1'b0;
          bus.MW_regWrite <= 1'b0;
        end
        is_lw: begin
          bus.MW_RD       <= bus.XM_RD;
          bus.MW_lwFlag   <= 1'b1;
          bus.MW_regWrite <= (bus.XM_RD != '0);
        end
        default: begin
          bus.MW_RD       <= bus.XM_RD;
          bus.MW_lwFlag   <= 1'b0;
          bus.MW_regWrite <= (bus.XM_RD != '0);
        end
      endcase
    end else begin
      bus.MW_RD       <= '0;
      bus.MW_lwFlag   <= 1'b0;
      bus.MW_regWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage against a word-array model.
// Wait-state scenarios are compiled in with DM_WAIT_EN.
module tb_memory_stage;
  import mips_pkg::*;

  localparam int DEPTH = 128;
`ifdef DM_WAIT_EN
  localparam int WAITS = 2;
`else
  localparam int WAITS = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_stage_if bus();

  memory_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] dm [DEPTH];
  logic [31:0] exp_mem;
  logic [70:0] exp_mw;
  int          exp_wait;
  int          waited;
  bit          bubble_ok;

  function automatic logic [70:0] mw_vec();
    return {bus.MW_ALUout, bus.MW_memData, bus.MW_RD,
            bus.MW_lwFlag, bus.MW_regWrite};
  endfunction

  // Reference: what the MW register must show after the op retires.
  function automatic void model(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  rd,
    input logic        lw,
    input logic        sw
  );
    int i;
    i = int'((a >> 2) % DEPTH);
    if (sw) begin
      dm[i]    = b;
      exp_mw   = {a, exp_mem, 5'd0, 1'b0, 1'b0};
      exp_wait = WAITS;
    end else if (lw) begin
      exp_mem  = dm[i];
      exp_mw   = {a, exp_mem, rd, 1'b1, rd != 5'd0};
      exp_wait = WAITS;
    end else begin
      exp_mw   = {a, exp_mem, rd, 1'b0, rd != 5'd0};
      exp_wait = 0;
    end
  endfunction

  task automatic drive(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  rd,
    input logic        lw,
    input logic        sw
  );
    bus.XM_ALUout = a;
    bus.XM_B      = b;
    bus.XM_RD     = rd;
    bus.XM_lwFlag = lw;
    bus.XM_swFlag = sw;
  endtask

  // Present one op, ride out the stall, stop just after its commit edge.
  task automatic issue(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  rd,
    input logic        lw,
    input logic        sw
  );
    @(negedge clk);
    drive(a, b, rd, lw, sw);
    waited    = 0;
    bubble_ok = 1'b1;
    #1;
    while (bus.stall === 1'b1 && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
      if (bus.MW_RD !== 5'd0 || bus.MW_lwFlag !== 1'b0 ||
          bus.MW_regWrite !== 1'b0)
        bubble_ok = 1'b0;
    end
    @(posedge clk);
    #1;
    model(a, b, rd, lw, sw);
  endtask

  task automatic test_reset();
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mw_vec() !== 71'd0) begin
      errors++;
      $display("FAIL reset_mw: got %h want 0", mw_vec());
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b want 0", bus.stall);
    end
    @(negedge clk);
    rst     = 1'b0;
    exp_mem = 32'h0;
  endtask

  task automatic test_alu();
    issue(32'h1234, 32'h0, 5'd5, 1'b0, 1'b0);
    checks++;
    if (mw_vec() !== {32'h1234, 32'h0, 5'd5, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL alu_basic: got %h want %h", mw_vec(),
               {32'h1234, 32'h0, 5'd5, 1'b0, 1'b1});
    end
    checks++;
    if (waited !== 0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_stall: got %0d/%b want 0/0", waited, bus.stall);
    end
  endtask

  task automatic test_sw_lw();
    issue(32'h10, 32'hDEADBEEF, 5'd3, 1'b0, 1'b1);
    checks++;
    if (bus.MW_regWrite !== 1'b0 || bus.MW_RD !== 5'd0) begin
      errors++;
      $display("FAIL sw_out: got rw=%b rd=%0d want 0/0",
               bus.MW_regWrite, bus.MW_RD);
    end
    issue(32'h10, 32'h0, 5'd8, 1'b1, 1'b0);
    checks++;
    if (mw_vec() !== {32'h10, 32'hDEADBEEF, 5'd8, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sw_lw: got %h want %h", mw_vec(),
               {32'h10, 32'hDEADBEEF, 5'd8, 1'b1, 1'b1});
    end
    checks++;
    if (waited !== WAITS || !bubble_ok) begin
      errors++;
      $display("FAIL lw_wait: got %0d bub=%b want %0d bub=1",
               waited, bubble_ok, WAITS);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      issue(32'(i * 4), $urandom, 5'($urandom), 1'b0, 1'b1);
      checks++;
      if (mw_vec() !== exp_mw || waited !== exp_wait || !bubble_ok) begin
        errors++;
        $display("FAIL fill[%0d]: got %h w=%0d want %h w=%0d",
                 i, mw_vec(), waited, exp_mw, exp_wait);
      end
    end
  endtask

  task automatic test_wrap();
    issue(32'h200, 32'h55, 5'd3, 1'b0, 1'b1);
    issue(32'h003, 32'h0, 5'd9, 1'b1, 1'b0);
    checks++;
    if (bus.MW_memData !== 32'h55) begin
      errors++;
      $display("FAIL wrap_align: got %h want 00000055", bus.MW_memData);
    end
    checks++;
    if (mw_vec() !== exp_mw) begin
      errors++;
      $display("FAIL wrap_vec: got %h want %h", mw_vec(), exp_mw);
    end
  endtask

  task automatic test_rd0_dual();
    issue(32'h44, 32'h0, 5'd0, 1'b1, 1'b0);
    checks++;
    if (bus.MW_regWrite !== 1'b0 || bus.MW_lwFlag !== 1'b1) begin
      errors++;
      $display("FAIL lw_rd0: got rw=%b lw=%b want 0/1",
               bus.MW_regWrite, bus.MW_lwFlag);
    end
    issue(32'h40, 32'hA5A5_5A5A, 5'd7, 1'b1, 1'b1);
    checks++;
    if (bus.MW_lwFlag !== 1'b0 || mw_vec() !== exp_mw) begin
      errors++;
      $display("FAIL dual_flags: got %h want %h", mw_vec(), exp_mw);
    end
    issue(32'h40, 32'h0, 5'd2, 1'b1, 1'b0);
    checks++;
    if (bus.MW_memData !== 32'hA5A5_5A5A) begin
      errors++;
      $display("FAIL dual_store: got %h want a5a55a5a", bus.MW_memData);
    end
  endtask

  task automatic test_random();
    logic [1:0] f;
    for (int n = 0; n < 300; n++) begin
      f = 2'($urandom);
      issue($urandom, $urandom, 5'($urandom_range(0, 31)), f[0], f[1]);
      checks++;
      if (mw_vec() !== exp_mw || waited !== exp_wait || !bubble_ok) begin
        errors++;
        $display("FAIL random[%0d]: got %h w=%0d want %h w=%0d",
                 n, mw_vec(), waited, exp_mw, exp_wait);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] d;
    for (int n = 0; n < 8; n++) begin
      a = $urandom;
      d = $urandom;
      issue(a, d, 5'd1, 1'b0, 1'b1);
      issue(a, 32'h0, 5'd6, 1'b1, 1'b0);
      checks++;
      if (bus.MW_memData !== d || mw_vec() !== exp_mw) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h want data %h", n, mw_vec(), d);
      end
      issue(a + 32'd4, 32'h0, 5'd11, 1'b0, 1'b0);
      checks++;
      if (waited !== 0 || mw_vec() !== exp_mw) begin
        errors++;
        $display("FAIL b2b_alu[%0d]: got %h w=%0d want %h w=0",
                 n, mw_vec(), waited, exp_mw);
      end
    end
  endtask

`ifdef DM_WAIT_EN
  task automatic test_reset_in_wait();
    logic [31:0] old;
    old = dm[8];
    @(negedge clk);
    drive(32'h20, 32'h77, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL wait_stall_on: got %b want 1", bus.stall);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || mw_vec() !== 71'd0) begin
      errors++;
      $display("FAIL wait_reset: got stall=%b mw=%h want 0/0",
               bus.stall, mw_vec());
    end
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst     = 1'b0;
    exp_mem = 32'h0;
    issue(32'h20, 32'h0, 5'd4, 1'b1, 1'b0);
    checks++;
    if (bus.MW_memData !== old || mw_vec() !== exp_mw) begin
      errors++;
      $display("FAIL wait_discard: got %h want data %h",
               bus.MW_memData, old);
    end
  endtask
`endif

  initial begin
    exp_mem  = 32'h0;
    exp_mw   = '0;
    exp_wait = 0;
    test_reset();
    test_alu();
    test_sw_lw();
    test_fill();
    test_wrap();
    test_rd0_dual();
    test_back_to_back();
    test_random();
`ifdef DM_WAIT_EN
    test_reset_in_wait();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

MEM stage of the five-stage MIPS pipeline. It sits directly downstream of the execution stage and consumes the XM pipeline register: the ALU result, the destination register and the load/store flags. It performs the data-memory access (word load/store) and drives the MW pipeline register into write-back. Optional wait states can emulate slower data memory, with a stall back to the upstream stages.

## Interface
Parameters:
- DM_DEPTH, 128: data-memory depth in 32-bit words; power of two.
- MEM_WAIT, 2: stall cycles per load/store; range 1..15. Used only with DM_WAIT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- XM_ALUout  in  32  byte address for lw/sw; pass-through result for ALU ops.
- XM_B  in  32  store data.
- XM_RD  in  5  destination register.
- XM_lwFlag  in  1  load.
- XM_swFlag  in  1  store.
- stall  out  1  hold request to upstream stages; combinational.
- MW_ALUout  out  32  registered ALU result.
- MW_memData  out  32  registered load data.
- MW_RD  out  5  registered destination; 0 = no write-back.
- MW_lwFlag  out  1  registered; selects MW_memData in write-back.
- MW_regWrite  out  1  registered; write-back enable.

## Operation
- Word index is XM_ALUout[log2(DM_DEPTH)+1:2].
  - Bits [1:0] are ignored.
  - Upper bits are ignored, so out-of-range addresses wrap modulo DM_DEPTH.
- Op decode:
  - sw: XM_swFlag=1. Takes priority if both flags are high.
  - lw: XM_lwFlag=1 and XM_swFlag=0.
  - ALU: neither flag set.
- Store: dm[idx] <= XM_B at the commit edge.
  - MW_RD <= 0, MW_lwFlag <= 0, MW_regWrite <= 0.
- Load: MW_memData <= dm[idx] at the commit edge.
  - MW_lwFlag <= 1, MW_RD <= XM_RD, MW_regWrite <= (XM_RD != 0).
- ALU op: MW_ALUout <= XM_ALUout, MW_RD <= XM_RD, MW_lwFlag <= 0, MW_regWrite <= (XM_RD != 0).
  - MW_memData holds its previous value.
- MW_ALUout always captures XM_ALUout at the commit edge.
- Memory is single-port, one access per commit. Memory contents are not cleared by reset.
- Reset values: MW_ALUout=0, MW_memData=0, MW_RD=0, MW_lwFlag=0, MW_regWrite=0, stall=0; FSM in IDLE, counter 0.

## Timing
- Without DM_WAIT_EN:
  - Every edge is a commit edge; latency is 1 cycle from XM_* to MW_*.
  - stall is tied to 0.
  - Back-to-back sw then lw to the same address: the lw returns the stored value.
- With DM_WAIT_EN, FSM states are IDLE and WAIT, with a 4-bit counter cnt:
  - IDLE, lw or sw present: stall=1, next state WAIT, cnt <= MEM_WAIT-1, no commit. MW outputs take a bubble (RD=0, lwFlag=0, regWrite=0).
  - WAIT, cnt!=0: stall=1, cnt decrements, bubble.
  - WAIT, cnt==0: stall=0, commit edge, next state IDLE.
  - IDLE, ALU op: stall=0, commit.
- Each memory op costs MEM_WAIT extra cycles; lw latency is MEM_WAIT+1 cycles.
- Upstream must hold XM_* stable while stall=1. Changes during WAIT are undefined.
- Reset during WAIT: return to IDLE at once, stall drops immediately, and the pending store is discarded (memory unchanged).
- A new memory op in the cycle right after a commit stalls again; no overlap.

## Configuration
- DM_WAIT_EN defined: wait-state FSM compiled in, stall driven as above, MEM_WAIT honoured.
- DM_WAIT_EN undefined: no FSM or counter, stall=0, single-cycle access, MEM_WAIT unused.

## Structure
- Shared package mips_pkg:
  - word width 32, register-index width 5;
  - DM_ADDR_W = log2(DM_DEPTH);
  - FSM state enum {IDLE, WAIT};
  - op-decode constants shared with the execution stage.
- Sub-module data_mem: single-port synchronous RAM.
  - Inputs: clk, we, addr, wdata. Output: registered rdata.
  - No reset on the array.
  - Instantiated once, with commit-qualified we and read enable.

## Test plan
- Reset then ALU op: XM_ALUout=0x1234, XM_RD=5 → next cycle MW_ALUout=0x1234, MW_RD=5, MW_regWrite=1, MW_lwFlag=0.
- sw then lw (no macro): sw addr 0x10, data 0xDEADBEEF; next cycle lw addr 0x10, RD=8 → MW_memData=0xDEADBEEF, MW_RD=8, MW_lwFlag=1. During the sw cycle's output: MW_regWrite=0, MW_RD=0.
- Wrap and alignment (DM_DEPTH=128): sw 0x55 to addr 0x200; lw addr 0x003 → 0x55. The 0x200 wraps to index 0 and 0x003 maps to index 0.
- RD=0 load and dual flags: lw with XM_RD=0 → MW_regWrite=0. lwFlag=1 and swFlag=1 together behave as a store: memory written, MW_lwFlag=0.
- DM_WAIT_EN, MEM_WAIT=2: lw issued → stall=1 for exactly 2 cycles with bubble outputs; data appears on the 3rd edge. A following ALU op sees no stall.
- DM_WAIT_EN, reset in WAIT: start sw 0x77 to addr 0x20, assert rst on the first stall cycle → stall=0 and all MW outputs 0. A later lw of 0x20 returns the old value, not 0x77.
